// File: rtl/tlb_entry_age_ctrl_if.sv
// Lookup-hit, refill and flush signals between the TLB datapath and the
// entry-age controller.
interface tlb_entry_age_ctrl_if;
   logic       hit_valid;
   logic [1:0] hit_id;
   logic       flush;
   logic       flush_all;
   logic       refill_req;
   logic       fill_done;
   logic       fill_G;
   logic       victim_valid;
   logic [1:0] victim_id;
   logic [3:0] entry_valid;
   logic [3:0] entry_G;
   logic       busy;

   modport master (
      output hit_valid, hit_id, flush, flush_all, refill_req, fill_done, fill_G,
      input  victim_valid, victim_id, entry_valid, entry_G, busy
   );

   modport slave (
      input  hit_valid, hit_id, flush, flush_all, refill_req, fill_done, fill_G,
      output victim_valid, victim_id, entry_valid, entry_G, busy
   );
endinterface

// File: rtl/tlb_entry_age_ctrl.sv
// Per-entry valid/global/access-count state for a 4-entry TLB, periodic aging,
// flush handling and tree-based victim selection held in a refill handshake.
module tlb_entry_age_ctrl #(
   parameter int unsigned CNT_W      = 12,
   parameter int unsigned AGE_PERIOD = 1024
) (
   input logic                  i_clk,
   input logic                  i_rst,
   tlb_entry_age_ctrl_if.slave  if_bus
);
   localparam int unsigned        TMR_W    = $clog2(AGE_PERIOD);
   localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(AGE_PERIOD - 1);

   typedef enum logic [1:0] {StIdle, StSelect, StWaitFill} state_e;

   state_e             r_state;
   logic               r_victim_valid;
   logic [1:0]         r_victim_id;
   logic               r_busy;
   logic [3:0]         r_valid;
   logic [3:0]         r_g;
   logic [CNT_W-1:0]   r_cnt [4];
   logic [TMR_W-1:0]   r_timer;

   logic               w_tick;
   logic               w_flush_any;
   logic               w_fill;
   logic [3:0]         w_valid_d;
   logic [3:0]         w_g_d;
   logic [CNT_W-1:0]   w_base [4];
   logic [CNT_W-1:0]   w_cnt_d [4];
   logic [1:0]         w_win_lo;
   logic [1:0]         w_win_hi;
   logic [1:0]         w_win;

   // Returns 1 when the higher-index entry b wins the pairwise compare.
   function automatic logic pick_hi(input logic va, input logic ga, input logic [CNT_W-1:0] ca,
                                    input logic vb, input logic gb, input logic [CNT_W-1:0] cb);
      logic hi;
      if (!va || !vb) begin
         hi = va;
      end else if (ga != gb) begin
         hi = ~gb;
      end else begin
         hi = (cb <= ca);
      end
      return hi;
   endfunction

   always_comb begin
      w_win_lo = pick_hi(r_valid[0], r_g[0], r_cnt[0], r_valid[1], r_g[1], r_cnt[1]) ?
                 2'd1 : 2'd0;
      w_win_hi = pick_hi(r_valid[2], r_g[2], r_cnt[2], r_valid[3], r_g[3], r_cnt[3]) ?
                 2'd3 : 2'd2;
      w_win    = pick_hi(r_valid[w_win_lo], r_g[w_win_lo], r_cnt[w_win_lo],
                         r_valid[w_win_hi], r_g[w_win_hi], r_cnt[w_win_hi]) ?
                 w_win_hi : w_win_lo;
   end

   assign w_tick      = (r_timer == TMR_LAST);
   assign w_flush_any = if_bus.flush | if_bus.flush_all;
   assign w_fill      = (r_state == StWaitFill) && if_bus.fill_done && !w_flush_any;

   // Priority: flush_all > flush > fill > hit > aging.
   always_comb begin
      w_valid_d = r_valid;
      w_g_d     = r_g;
      for (int i = 0; i < 4; i++) begin
         w_base[i]  = w_tick ? (r_cnt[i] >> 1) : r_cnt[i];
         w_cnt_d[i] = w_base[i];
         if (if_bus.flush_all) begin
            w_valid_d[i] = 1'b0;
            w_g_d[i]     = 1'b0;
            w_cnt_d[i]   = '0;
         end else if (if_bus.flush && !r_g[i]) begin
            w_valid_d[i] = 1'b0;
            w_cnt_d[i]   = '0;
         end else if (w_fill && (r_victim_id == 2'(i))) begin
            w_valid_d[i] = 1'b1;
            w_g_d[i]     = if_bus.fill_G;
            w_cnt_d[i]   = '0;
         end else if (if_bus.hit_valid && (if_bus.hit_id == 2'(i)) && r_valid[i] &&
                      !(&w_base[i])) begin
            w_cnt_d[i] = w_base[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= '0;
         r_g     <= '0;
         r_timer <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_valid <= w_valid_d;
         r_g     <= w_g_d;
         r_timer <= w_tick ? '0 : r_timer + 1'b1;
         for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_d[i];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= StIdle;
         r_victim_valid <= 1'b0;
         r_victim_id    <= 2'd0;
         r_busy         <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (if_bus.refill_req) begin
                  r_state <= StSelect;
                  r_busy  <= 1'b1;
               end
            end
            StSelect: begin
               if (w_flush_any) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end else begin
                  r_state        <= StWaitFill;
                  r_victim_id    <= w_win;
                  r_victim_valid <= 1'b1;
               end
            end
            StWaitFill: begin
               if (w_flush_any || if_bus.fill_done) begin
                  r_state        <= StIdle;
                  r_victim_valid <= 1'b0;
                  r_busy         <= 1'b0;
               end
            end
            default: begin
               r_state        <= StIdle;
               r_victim_valid <= 1'b0;
               r_busy         <= 1'b0;
            end
         endcase
      end
   end

   assign if_bus.victim_valid = r_victim_valid;
   assign if_bus.victim_id    = r_victim_id;
   assign if_bus.entry_valid  = r_valid;
   assign if_bus.entry_G      = r_g;
   assign if_bus.busy         = r_busy;
endmodule
